// File: rtl/modulus_chunk_seq.sv
// modulus_chunk_seq
// Sequenced modulus-term generator for the modular-square reduction path.
// One chunk address (SEG_COUNT segments of SEG_BITS bits) is accepted. Its
// reduced terms (v * 2^(CUR_LOW_POS + s*SEG_BITS)) mod MODULUS are then emitted
// LANES segments per beat over a valid/ready output stream.
//
// Handshake rules (both ports): a transfer happens on a rising clk_phase edge
// where valid && ready are both 1. A source holds valid and data stable until
// that edge. The output register is free when !out_valid || out_ready.
// in_ready is asserted only in IDLE while the output register is free, and is
// held low during reset.
//
// Optional feature macro: MODULUS_CHUNK_ZERO_SKIP_EN. When it is defined,
// beats whose LANES segment values are all zero are not emitted. An all-zero
// chunk still emits one zero beat with out_last set.
module modulus_chunk_seq #(
  parameter int MODULUS_WIDTH = 1024,
  parameter logic [MODULUS_WIDTH-1:0] MODULUS = '1,
  parameter int SEG_BITS = 5,
  parameter int SEG_COUNT = 3,
  parameter int LANES = 3,
  parameter int CUR_LOW_POS = MODULUS_WIDTH*2 - SEG_BITS*SEG_COUNT,
  localparam int IDX_W = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1
) (
  input  logic                                clk_phase,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SEG_BITS*SEG_COUNT-1:0]       in_addr,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES-1:0][MODULUS_WIDTH-1:0] out_terms,
  output logic [IDX_W-1:0]                    out_seg_idx,
  output logic                                out_last,
  output logic                                dbg_state
);

  localparam int W     = MODULUS_WIDTH;
  localparam int AW    = SEG_BITS*SEG_COUNT;
  localparam int NV    = 2**SEG_BITS;
  localparam int BEATS = SEG_COUNT / LANES;
  localparam int BW    = $clog2(BEATS + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  if (SEG_COUNT % LANES != 0) begin : g_bad_lanes
    $error("modulus_chunk_seq: SEG_COUNT must be a multiple of LANES");
  end

  // Elaboration-time modular helpers; they are used only to build constant ROM contents.
  function automatic logic [W-1:0] mul_mod(logic [W-1:0] a, logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, MODULUS};
    return p[W-1:0];
  endfunction

  // 2^e mod MODULUS by square-and-multiply, so large exponents stay cheap.
  function automatic logic [W-1:0] pow2_mod(int unsigned e);
    logic [W-1:0] acc;
    logic [W-1:0] base;
    logic [31:0]  ebits;
    ebits = e;
    acc   = mul_mod(W'(1), W'(1));
    base  = mul_mod(W'(2), W'(1));
    for (int i = 0; i < 32; i++) begin
      if (ebits[i]) acc = mul_mod(acc, base);
      base = mul_mod(base, base);
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] rom_term(int s, int v);
    return mul_mod(W'(v), pow2_mod(unsigned'(CUR_LOW_POS + s*SEG_BITS)));
  endfunction

  // Lowest beat index >= start whose mask bit is set, or BEATS if none.
  function automatic int first_from(logic [BEATS-1:0] m, int start);
    int r;
    r = BEATS;
    for (int b = BEATS-1; b >= 0; b--) begin
      if (b >= start && m[b]) r = b;
    end
    return r;
  endfunction

  logic [W-1:0] rom [SEG_COUNT][NV];

  for (genvar gs = 0; gs < SEG_COUNT; gs++) begin : g_seg
    for (genvar gv = 0; gv < NV; gv++) begin : g_val
      localparam logic [W-1:0] TERM = rom_term(gs, gv);
      assign rom[gs][gv] = TERM;
    end
  end

  logic [0:0]               state;
  logic [AW-1:0]            addr_reg;
  logic [BW-1:0]            beat_cnt;
  logic                     out_free;
  logic [BEATS-1:0]         mask_in;
  logic [BEATS-1:0]         mask_reg;
  logic [LANES-1:0][W-1:0]  terms_in  [BEATS];
  logic [LANES-1:0][W-1:0]  terms_reg [BEATS];
  logic [LANES-1:0][W-1:0]  acc_terms;
  logic [LANES-1:0][W-1:0]  iss_terms;
  int                       acc_beat;
  int                       acc_next;
  int                       iss_next;

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = rst_n && (state == IDLE) && out_free;
  assign dbg_state = state;

  // ROM lookups for every beat of both the incoming address and the latched address.
  always_comb begin
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        terms_in[b][l]  = rom[b*LANES+l][in_addr[(b*LANES+l)*SEG_BITS +: SEG_BITS]];
        terms_reg[b][l] = rom[b*LANES+l][addr_reg[(b*LANES+l)*SEG_BITS +: SEG_BITS]];
      end
    end
  end

  // Beats eligible for emission: non-zero beats with skipping on, every beat otherwise.
  always_comb begin
`ifdef MODULUS_CHUNK_ZERO_SKIP_EN
    for (int b = 0; b < BEATS; b++) begin
      mask_in[b]  = |in_addr[b*LANES*SEG_BITS +: LANES*SEG_BITS];
      mask_reg[b] = |addr_reg[b*LANES*SEG_BITS +: LANES*SEG_BITS];
    end
`else
    mask_in  = '1;
    mask_reg = '1;
`endif
  end

  // Beat selection: the first beat on accept, and the following beat while issuing.
  always_comb begin
    acc_beat = first_from(mask_in, 0);
    if (acc_beat == BEATS) acc_beat = 0;
    acc_next = first_from(mask_in, acc_beat + 1);
    iss_next = first_from(mask_reg, int'(beat_cnt) + 1);
    acc_terms = '0;
    iss_terms = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (b == acc_beat)       acc_terms = terms_in[b];
      if (b == int'(beat_cnt)) iss_terms = terms_reg[b];
    end
  end

  // Control FSM and output register; they load only when the output register is free.
  always_ff @(posedge clk_phase) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_terms   <= '0;
      out_seg_idx <= '0;
      out_last    <= 1'b0;
      beat_cnt    <= '0;
      addr_reg    <= '0;
    end else if (out_free) begin
      if (state == ISSUE) begin
        out_valid   <= 1'b1;
        out_terms   <= iss_terms;
        out_seg_idx <= IDX_W'(int'(beat_cnt) * LANES);
        out_last    <= (iss_next == BEATS);
        if (iss_next == BEATS) begin
          state    <= IDLE;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= BW'(iss_next);
        end
      end else if (in_valid) begin
        addr_reg    <= in_addr;
        out_valid   <= 1'b1;
        out_terms   <= acc_terms;
        out_seg_idx <= IDX_W'(acc_beat * LANES);
        out_last    <= (acc_next == BEATS);
        if (acc_next != BEATS) begin
          state    <= ISSUE;
          beat_cnt <= BW'(acc_next);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/modulus_chunk_seq.md
# modulus_chunk_seq

Sequenced, parametrised modulus-term generator for the modular-square reduction path. It accepts one chunk address of SEG_COUNT segments of SEG_BITS bits each. It emits the reduced terms (v · 2^(CUR_LOW_POS + s·SEG_BITS)) mod MODULUS, LANES segments per beat, over a valid/ready stream. It succeeds the fixed three-quint, bypass-registered chunk: segment width, segment count and lanes per beat are now generic, and it adds backpressure, multi-beat sequencing and optional zero-segment skipping.

## Interface
- MODULUS_WIDTH, 1024, width of the modulus and of every term.
- MODULUS, all-ones of MODULUS_WIDTH, modulus constant; ROM contents are computed from it at elaboration.
- SEG_BITS, 5, bits per segment.
- SEG_COUNT, 3, segments per chunk.
- LANES, 3, segments emitted per beat. SEG_COUNT % LANES must be 0; elaboration fails otherwise. BEATS = SEG_COUNT/LANES.
- CUR_LOW_POS, MODULUS_WIDTH*2 - SEG_BITS*SEG_COUNT, bit position of segment 0.
- clk_phase  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  chunk address valid.
- in_ready  out  1  block can accept a chunk this cycle.
- in_addr  in  SEG_BITS*SEG_COUNT  segment s = in_addr[s*SEG_BITS +: SEG_BITS].
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_terms  out  LANES × MODULUS_WIDTH  out_terms[l] is the term of segment out_seg_idx+l.
- out_seg_idx  out  clog2(SEG_COUNT)  index of the segment in lane 0.
- out_last  out  1  final beat of the chunk.

## Operation
- ROM: term[s][v] = (v · 2^(CUR_LOW_POS+s·SEG_BITS)) mod MODULUS, for v in 0..2^SEG_BITS-1. The table is built by an elaboration-time function with no runtime arithmetic.
- States: IDLE and ISSUE. The internal registers are addr_reg and beat_cnt.
- Output register is "free" when !out_valid || out_ready.
- in_ready = (state==IDLE) && free.
- On accept (in_valid && in_ready):
  - latch in_addr into addr_reg;
  - load the first beat into the output register using in_addr directly;
  - if BEATS==1 (after skipping), set out_last=1 and stay in IDLE;
  - otherwise go to ISSUE with beat_cnt pointing at the next beat.
- In ISSUE, on each cycle the output register is free:
  - load beat beat_cnt from addr_reg;
  - set out_last when this is the final beat;
  - after the final beat, go to IDLE.
- The output register holds its value while out_valid && !out_ready; no beat is dropped or duplicated.
- out_seg_idx = beat·LANES.

## Timing
- Reset values: state IDLE, out_valid 0, out_terms all 0, out_seg_idx 0, out_last 0, beat_cnt 0, addr_reg 0.
- in_ready is 0 during reset.
- Latency: a chunk accepted in cycle t has its first beat valid in cycle t+1.
- Without backpressure, beats appear on consecutive cycles.
- Throughput:
  - with BEATS==1 and out_ready held at 1, one chunk is accepted per cycle;
  - otherwise the next chunk is accepted in the cycle the final beat is consumed, with no bubble.
- in_valid while in_ready=0 is ignored; the source must hold the address until accepted.
- Reset asserted mid-chunk abandons the chunk; remaining beats are never emitted.

## Configuration
- MODULUS_CHUNK_ZERO_SKIP_EN defined:
  - a beat whose LANES segment values are all zero is not emitted;
  - the next non-zero beat is chosen by a priority encoder over the beat-zero mask;
  - out_last marks the last non-zero beat;
  - an all-zero chunk emits exactly one beat: out_terms 0, out_seg_idx 0, out_last 1.
- MODULUS_CHUNK_ZERO_SKIP_EN undefined: all BEATS beats are always emitted, including all-zero beats.

## Test plan
Bench parameters: MODULUS_WIDTH=8, MODULUS=251, SEG_BITS=2, SEG_COUNT=4, LANES=2, CUR_LOW_POS=8. The per-segment multipliers are 5, 20, 80, 69.
- Basic: in_addr=8'b11_10_01_11 with out_ready=1 -> cycle t+1: terms {15,20}, idx 0, last 0; cycle t+2: terms {160,207}, idx 2, last 1.
- Backpressure: same chunk, out_ready=0 for 3 cycles after the first beat -> {15,20} held stable, in_ready=0, then {160,207} follows; no loss.
- Back-to-back: two chunks offered with in_valid=1 continuously -> the second is accepted in the cycle {160,207} is consumed, and its first beat follows in the next cycle.
- Zero skip (macro on): in_addr=8'b01_00_00_00 -> a single beat {0,69}, idx 2, last 1. Macro off -> {0,0} idx 0 last 0, then {0,69} idx 2 last 1.
- All zero (macro on): in_addr=0 -> one beat {0,0}, idx 0, last 1.
- Reset: rst_n=0 for one cycle after the first beat -> out_valid=0 and outputs zero next cycle; no second beat; in_ready=1 afterwards.
